// File: rtl/rename_ctrl_pkg.sv
// Shared definitions for the rename stage controller: default widths,
// the reserved "no tag" encoding and the sequencer state encoding.
package rename_ctrl_pkg;

  localparam int ROB_TAG_LEN_DEF  = 3;
  localparam int REG_ADDR_LEN_DEF = 5;
  // src1, src2 and dest packed side by side
  localparam int ARCH_REG_FIELDS  = 3;

  // Tags 0..2^N-2 are allocatable; all-ones means "no tag" in the map table.
  localparam int ROB_SIZE_DEF = (1 << ROB_TAG_LEN_DEF) - 1;
  localparam logic [ROB_TAG_LEN_DEF-1:0] NO_TAG = {ROB_TAG_LEN_DEF{1'b1}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } rename_state_e;

endpackage

// File: rtl/rename_ctrl_rob_tag_alloc.sv
// Circular ROB tag allocator: tail pointer of the next tag to hand out and
// the count of tags still free. Clear restores the empty-ROB condition.
module rename_ctrl_rob_tag_alloc
  import rename_ctrl_pkg::*;
#(
  parameter int ROB_TAG_LEN = ROB_TAG_LEN_DEF,
  parameter int ROB_SIZE    = (1 << ROB_TAG_LEN) - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_i,
  input  logic                   free_i,
  input  logic                   clear_i,
  output logic [ROB_TAG_LEN-1:0] tag_o,
  output logic [ROB_TAG_LEN-1:0] free_cnt_o,
  output logic                   empty_o
);

  localparam logic [ROB_TAG_LEN-1:0] SIZE_V = ROB_TAG_LEN'(ROB_SIZE);
  localparam logic [ROB_TAG_LEN-1:0] LAST_V = ROB_TAG_LEN'(ROB_SIZE - 1);

  logic [ROB_TAG_LEN-1:0] tail_q, tail_d;
  logic [ROB_TAG_LEN-1:0] free_cnt_q, free_cnt_d;

  // Next tail / free count: clear wins, alloc and free cancel each other out
  always_comb begin
    tail_d     = tail_q;
    free_cnt_d = free_cnt_q;
    if (clear_i) begin
      tail_d     = '0;
      free_cnt_d = SIZE_V;
    end else begin
      if (alloc_i) begin
        tail_d = (tail_q == LAST_V) ? '0 : tail_q + 1'b1;
      end
      case ({alloc_i, free_i})
        2'b10:   free_cnt_d = free_cnt_q - 1'b1;
        2'b01: begin
          // A return with nothing outstanding is bogus; hold at full.
          if (free_cnt_q != SIZE_V) free_cnt_d = free_cnt_q + 1'b1;
        end
        default: free_cnt_d = free_cnt_q;
      endcase
    end
  end

  // Allocator state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_q     <= '0;
      free_cnt_q <= SIZE_V;
    end else begin
      tail_q     <= tail_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign tag_o      = tail_q;
  assign free_cnt_o = free_cnt_q;
  assign empty_o    = (free_cnt_q == '0);

  // Commit arriving while every tag is already free means the ROB lost track
  a_no_free_when_full: assert property (
    @(posedge clk) disable iff (reset)
      !(free_i && !clear_i && (free_cnt_q == SIZE_V)));

endmodule

// File: rtl/rename_ctrl.sv
// Rename stage sequencer: one-entry hold register for the decoded instruction,
// RUN/STALL/FLUSH control, ROB tag allocation and map table command muxing.
module rename_ctrl
  import rename_ctrl_pkg::*;
#(
  parameter int ROB_TAG_LEN  = ROB_TAG_LEN_DEF,
  parameter int ROB_SIZE     = (1 << ROB_TAG_LEN) - 1,
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int ARCH_REG_LEN = ARCH_REG_FIELDS * REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ARCH_REG_LEN-1:0] in_arch_reg,
  input  logic                    in_has_dest,
  input  logic                    rs_full,
  input  logic                    commit_valid,
  input  logic [REG_ADDR_LEN-1:0] commit_reg,
  input  logic [ROB_TAG_LEN-1:0]  commit_tag,
  input  logic                    cdb_valid,
  input  logic [ROB_TAG_LEN-1:0]  cdb_tag,
  input  logic                    flush,
  output logic [ARCH_REG_LEN-1:0] arch_reg,
  output logic                    assign_flag,
  output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
  output logic                    return_flag,
  output logic [REG_ADDR_LEN-1:0] reg_addr_from_rob,
  output logic [ROB_TAG_LEN-1:0]  rob_tag_from_rob,
  output logic                    ready_flag,
  output logic [ROB_TAG_LEN-1:0]  rob_tag_from_cdb,
  output logic                    mt_clear,
  output logic                    disp_valid
);

  rename_state_e state_q, state_d;

  logic                    hold_valid_q, hold_valid_d;
  logic [ARCH_REG_LEN-1:0] hold_reg_q, hold_reg_d;
  logic                    hold_has_dest_q, hold_has_dest_d;

  logic                    alloc_empty;
  logic [ROB_TAG_LEN-1:0]  alloc_tag;
  logic [ROB_TAG_LEN-1:0]  alloc_free_cnt;

  logic st_run;
  logic st_flush;
  logic can_fire;
  logic fire;
  logic accept;

  assign st_run   = (state_q == RUN);
  assign st_flush = (state_q == FLUSH);
  // Resources available regardless of state; used to leave STALL
  assign can_fire = hold_valid_q & ~alloc_empty & ~rs_full;
  // A flush in the same cycle squashes the held instruction instead of issuing it
  assign fire     = st_run & can_fire & ~flush;
  // Decode is not accepted on a flush cycle so nothing it hands over is lost
  assign in_ready = st_run & ~flush & (~hold_valid_q | fire);
  assign accept   = in_valid & in_ready;

  rename_ctrl_rob_tag_alloc #(
    .ROB_TAG_LEN (ROB_TAG_LEN),
    .ROB_SIZE    (ROB_SIZE)
  ) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .alloc_i    (fire),
    .free_i     (commit_valid),
    .clear_i    (st_flush),
    .tag_o      (alloc_tag),
    .free_cnt_o (alloc_free_cnt),
    .empty_o    (alloc_empty)
  );

  // Hold register next state: emptied in FLUSH, loaded on accept, drained on fire
  always_comb begin
    hold_valid_d    = hold_valid_q;
    hold_reg_d      = hold_reg_q;
    hold_has_dest_d = hold_has_dest_q;
    if (st_flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d    = 1'b1;
      hold_reg_d      = in_arch_reg;
      hold_has_dest_d = in_has_dest;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
  end

  // Next-state logic of the RUN/STALL/FLUSH sequencer
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN:     if (hold_valid_q && !fire) state_d = STALL;
        STALL:   if (can_fire) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // State and hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      hold_valid_q    <= 1'b0;
      hold_reg_q      <= '0;
      hold_has_dest_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_valid_q    <= hold_valid_d;
      hold_reg_q      <= hold_reg_d;
      hold_has_dest_q <= hold_has_dest_d;
    end
  end

  // Map table / dispatch command outputs; commit and CDB pass through except in FLUSH
  always_comb begin
    disp_valid        = fire;
    assign_flag       = fire & hold_has_dest_q;
    arch_reg          = hold_reg_q;
    assign_rob_tag    = alloc_tag;
    return_flag       = ~st_flush & commit_valid;
    reg_addr_from_rob = commit_reg;
    rob_tag_from_rob  = commit_tag;
    ready_flag        = ~st_flush & cdb_valid;
    rob_tag_from_cdb  = cdb_tag;
    mt_clear          = st_flush;
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl with hand-computed expectations.
module tb_rename_ctrl;
  import rename_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_arch_reg;
  logic        in_has_dest;
  logic        rs_full;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [2:0]  commit_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic        flush;
  logic [14:0] arch_reg;
  logic        assign_flag;
  logic [2:0]  assign_rob_tag;
  logic        return_flag;
  logic [4:0]  reg_addr_from_rob;
  logic [2:0]  rob_tag_from_rob;
  logic        ready_flag;
  logic [2:0]  rob_tag_from_cdb;
  logic        mt_clear;
  logic        disp_valid;

  int checks = 0;
  int errors = 0;

  rename_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_arch_reg       (in_arch_reg),
    .in_has_dest       (in_has_dest),
    .rs_full           (rs_full),
    .commit_valid      (commit_valid),
    .commit_reg        (commit_reg),
    .commit_tag        (commit_tag),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .flush             (flush),
    .arch_reg          (arch_reg),
    .assign_flag       (assign_flag),
    .assign_rob_tag    (assign_rob_tag),
    .return_flag       (return_flag),
    .reg_addr_from_rob (reg_addr_from_rob),
    .rob_tag_from_rob  (rob_tag_from_rob),
    .ready_flag        (ready_flag),
    .rob_tag_from_cdb  (rob_tag_from_cdb),
    .mt_clear          (mt_clear),
    .disp_valid        (disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per dispatched instruction
  always @(negedge clk) begin
    if (!reset && disp_valid)
      $display("DISP t=%0t tag=%0d dest=%0b arch=%h", $time, assign_rob_tag, assign_flag, arch_reg);
  end

  function automatic logic [14:0] pattern(input int c);
    pattern = {5'(c + 1), 5'(c + 2), 5'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; in_arch_reg = '0; in_has_dest = 1'b0;
    rs_full = 1'b0; commit_valid = 1'b0; commit_reg = '0; commit_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp: got %0b expected 0", disp_valid); end
    checks++; if (assign_flag !== 1'b0) begin errors++; $display("FAIL reset_assign: got %0b expected 0", assign_flag); end
    checks++; if (mt_clear !== 1'b0) begin errors++; $display("FAIL reset_mt_clear: got %0b expected 0", mt_clear); end
    checks++; if (return_flag !== 1'b0 || ready_flag !== 1'b0) begin errors++; $display("FAIL reset_flags: got ret=%0b rdy=%0b expected 0 0", return_flag, ready_flag); end
    checks++; if (dut.u_alloc.free_cnt_q !== 3'd7) begin errors++; $display("FAIL reset_free_cnt: got %0d expected 7", dut.u_alloc.free_cnt_q); end
    checks++; if (assign_rob_tag !== 3'd0) begin errors++; $display("FAIL reset_tail: got %0d expected 0", assign_rob_tag); end
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, RUN); end
    tick();
  endtask

  // Fill all seven tags, eighth instruction stays held
  task automatic test_back_to_back();
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 8); in_arch_reg = pattern(c); in_has_dest = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        checks++; if (assign_flag !== 1'b0) begin errors++; $display("FAIL b2b_first_assign: got %0b expected 0", assign_flag); end
      end else if (c <= 7) begin
        checks++; if (assign_flag !== 1'b1) begin errors++; $display("FAIL b2b_assign c=%0d: got %0b expected 1", c, assign_flag); end
        checks++; if (assign_rob_tag !== 3'(c - 1)) begin errors++; $display("FAIL b2b_tag c=%0d: got %0d expected %0d", c, assign_rob_tag, c - 1); end
        checks++; if (arch_reg !== pattern(c - 1)) begin errors++; $display("FAIL b2b_arch c=%0d: got %h expected %h", c, arch_reg, pattern(c - 1)); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d: got %0b expected 1", c, in_ready); end
      end else begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b expected 0", in_ready); end
        checks++; if (assign_flag !== 1'b0) begin errors++; $display("FAIL b2b_full_assign: got %0b expected 0 (tag %0d)", assign_flag, assign_rob_tag); end
        checks++; if (dut.u_alloc.free_cnt_q !== 3'd0) begin errors++; $display("FAIL b2b_free_cnt: got %0d expected 0", dut.u_alloc.free_cnt_q); end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== STALL) begin errors++; $display("FAIL b2b_stall: got %0d expected %0d", dut.state_q, STALL); end
    checks++; if (in_ready !== 1'b0 || disp_valid !== 1'b0) begin errors++; $display("FAIL b2b_stall_out: got rdy=%0b disp=%0b expected 0 0", in_ready, disp_valid); end
    tick();
  endtask

  // Continues from the full state left by test_back_to_back
  task automatic test_commit_wrap();
    commit_valid = 1'b1; commit_reg = 5'd4; commit_tag = 3'd0;
    @(negedge clk);
    checks++; if (return_flag !== 1'b1) begin errors++; $display("FAIL cw_return: got %0b expected 1", return_flag); end
    checks++; if (reg_addr_from_rob !== 5'd4 || rob_tag_from_rob !== 3'd0) begin errors++; $display("FAIL cw_return_data: got reg=%0d tag=%0d expected 4 0", reg_addr_from_rob, rob_tag_from_rob); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL cw_no_disp0: got %0b expected 0", disp_valid); end
    tick();
    commit_valid = 1'b0;
    @(negedge clk);
    checks++; if (dut.u_alloc.free_cnt_q !== 3'd1) begin errors++; $display("FAIL cw_free_cnt: got %0d expected 1", dut.u_alloc.free_cnt_q); end
    checks++; if (dut.state_q !== STALL || disp_valid !== 1'b0) begin errors++; $display("FAIL cw_transition: got state=%0d disp=%0b expected %0d 0", dut.state_q, disp_valid, STALL); end
    tick();
    @(negedge clk);
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL cw_run: got %0d expected %0d", dut.state_q, RUN); end
    checks++; if (disp_valid !== 1'b1 || assign_flag !== 1'b1) begin errors++; $display("FAIL cw_fire: got disp=%0b assign=%0b expected 1 1", disp_valid, assign_flag); end
    checks++; if (assign_rob_tag !== 3'd0) begin errors++; $display("FAIL cw_wrap_tag: got %0d expected 0", assign_rob_tag); end
    checks++; if (arch_reg !== pattern(7)) begin errors++; $display("FAIL cw_arch: got %h expected %h", arch_reg, pattern(7)); end
    tick();
    @(negedge clk);
    checks++; if (dut.u_alloc.free_cnt_q !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL cw_after: got free=%0d rdy=%0b expected 0 1", dut.u_alloc.free_cnt_q, in_ready); end
    tick();
  endtask

  // Commit coincides with a fire at free_cnt == 3
  task automatic test_commit_fire();
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 5); in_arch_reg = pattern(c + 20); in_has_dest = 1'b1;
      commit_valid = (c == 5); commit_reg = 5'd1; commit_tag = 3'd0;
      @(negedge clk);
      if (c == 5) begin
        checks++; if (disp_valid !== 1'b1 || assign_rob_tag !== 3'd4) begin errors++; $display("FAIL cf_fire: got disp=%0b tag=%0d expected 1 4", disp_valid, assign_rob_tag); end
        checks++; if (dut.u_alloc.free_cnt_q !== 3'd3) begin errors++; $display("FAIL cf_free_before: got %0d expected 3", dut.u_alloc.free_cnt_q); end
      end
      tick();
    end
    in_valid = 1'b1; in_arch_reg = pattern(25); commit_valid = 1'b0;
    @(negedge clk);
    checks++; if (dut.u_alloc.free_cnt_q !== 3'd3) begin errors++; $display("FAIL cf_free_after: got %0d expected 3", dut.u_alloc.free_cnt_q); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || assign_rob_tag !== 3'd5) begin errors++; $display("FAIL cf_next_tag: got disp=%0b tag=%0d expected 1 5", disp_valid, assign_rob_tag); end
    tick();
  endtask

  // rs_full for three cycles with an instruction held
  task automatic test_rs_stall();
    reset_dut();
    in_valid = 1'b1; in_arch_reg = pattern(30); in_has_dest = 1'b1;
    tick();
    in_arch_reg = pattern(31);
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || assign_rob_tag !== 3'd0) begin errors++; $display("FAIL rs_first: got disp=%0b tag=%0d expected 1 0", disp_valid, assign_rob_tag); end
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rs_full = 1'b1;
      @(negedge clk);
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rs_disp c=%0d: got %0b expected 0", c, disp_valid); end
      checks++; if (c > 0 && dut.state_q !== STALL) begin errors++; $display("FAIL rs_state c=%0d: got %0d expected %0d", c, dut.state_q, STALL); end
      checks++; if (assign_rob_tag !== 3'd1) begin errors++; $display("FAIL rs_tag_hold c=%0d: got %0d expected 1", c, assign_rob_tag); end
      tick();
    end
    rs_full = 1'b0;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b0 || dut.state_q !== STALL) begin errors++; $display("FAIL rs_release: got disp=%0b state=%0d expected 0 %0d", disp_valid, dut.state_q, STALL); end
    tick();
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || assign_rob_tag !== 3'd1) begin errors++; $display("FAIL rs_fire: got disp=%0b tag=%0d expected 1 1", disp_valid, assign_rob_tag); end
    checks++; if (arch_reg !== pattern(31)) begin errors++; $display("FAIL rs_arch: got %h expected %h", arch_reg, pattern(31)); end
    tick();
  endtask

  // Flush with an instruction held and tail at 5
  task automatic test_flush();
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_arch_reg = pattern(c + 10); in_has_dest = 1'b1;
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++; if (assign_rob_tag !== 3'd5) begin errors++; $display("FAIL fl_tail: got %0d expected 5", assign_rob_tag); end
    checks++; if (disp_valid !== 1'b0 || assign_flag !== 1'b0) begin errors++; $display("FAIL fl_priority: got disp=%0b assign=%0b expected 0 0", disp_valid, assign_flag); end
    tick();
    flush = 1'b0; commit_valid = 1'b1; commit_reg = 5'd2; commit_tag = 3'd0; cdb_valid = 1'b1; cdb_tag = 3'd1;
    @(negedge clk);
    checks++; if (mt_clear !== 1'b1) begin errors++; $display("FAIL fl_mt_clear: got %0b expected 1", mt_clear); end
    checks++; if (in_ready !== 1'b0 || disp_valid !== 1'b0) begin errors++; $display("FAIL fl_ready: got rdy=%0b disp=%0b expected 0 0", in_ready, disp_valid); end
    checks++; if (return_flag !== 1'b0 || ready_flag !== 1'b0) begin errors++; $display("FAIL fl_gated: got ret=%0b rdy=%0b expected 0 0", return_flag, ready_flag); end
    tick();
    commit_valid = 1'b0; cdb_valid = 1'b0; in_valid = 1'b1; in_arch_reg = pattern(50);
    @(negedge clk);
    checks++; if (mt_clear !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_after: got clr=%0b rdy=%0b expected 0 1", mt_clear, in_ready); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL fl_discard: got %0b expected 0", disp_valid); end
    checks++; if (dut.u_alloc.free_cnt_q !== 3'd7) begin errors++; $display("FAIL fl_free_cnt: got %0d expected 7", dut.u_alloc.free_cnt_q); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || assign_rob_tag !== 3'd0) begin errors++; $display("FAIL fl_new_tag: got disp=%0b tag=%0d expected 1 0", disp_valid, assign_rob_tag); end
    tick();
  endtask

  // Instruction without dest still consumes a tag; CDB pass-through
  task automatic test_no_dest();
    reset_dut();
    in_valid = 1'b1; in_arch_reg = pattern(40); in_has_dest = 1'b0;
    tick();
    in_arch_reg = pattern(41); in_has_dest = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd3;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || assign_flag !== 1'b0) begin errors++; $display("FAIL nd_flags: got disp=%0b assign=%0b expected 1 0", disp_valid, assign_flag); end
    checks++; if (assign_rob_tag !== 3'd0) begin errors++; $display("FAIL nd_tag: got %0d expected 0", assign_rob_tag); end
    checks++; if (ready_flag !== 1'b1 || rob_tag_from_cdb !== 3'd3) begin errors++; $display("FAIL nd_cdb: got rdy=%0b tag=%0d expected 1 3", ready_flag, rob_tag_from_cdb); end
    tick();
    in_valid = 1'b0; cdb_valid = 1'b0;
    @(negedge clk);
    checks++; if (assign_flag !== 1'b1 || assign_rob_tag !== 3'd1) begin errors++; $display("FAIL nd_next: got assign=%0b tag=%0d expected 1 1", assign_flag, assign_rob_tag); end
    checks++; if (ready_flag !== 1'b0) begin errors++; $display("FAIL nd_cdb_off: got %0b expected 0", ready_flag); end
    tick();
  endtask

  // Reset asserted while an instruction is held and tail is non-zero
  task automatic test_reset_midop();
    reset_dut();
    in_valid = 1'b1; in_arch_reg = pattern(60); in_has_dest = 1'b1;
    tick();
    in_arch_reg = pattern(61);
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dut.u_alloc.free_cnt_q !== 3'd7 || dut.state_q !== RUN) begin errors++; $display("FAIL mr_state: got free=%0d state=%0d expected 7 %0d", dut.u_alloc.free_cnt_q, dut.state_q, RUN); end
    checks++; if (in_ready !== 1'b1 || disp_valid !== 1'b0) begin errors++; $display("FAIL mr_out: got rdy=%0b disp=%0b expected 1 0", in_ready, disp_valid); end
    in_valid = 1'b1; in_arch_reg = pattern(62);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || assign_rob_tag !== 3'd0) begin errors++; $display("FAIL mr_tag: got disp=%0b tag=%0d expected 1 0", disp_valid, assign_rob_tag); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_commit_wrap();
    test_commit_fire();
    test_rs_stall();
    test_flush();
    test_no_dest();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
